// File: rtl/axi_id_remap_if.sv
// axi_intf: AXI4 bundle shared by both sides of the ID remapper.
//   Parameters: ID_W (ID width), ADDR_W (address width), DATA_W (data width).
//   Channels: AW, W, B, AR, R. The W channel keeps a wid field so that the
//   compressed downstream side can tag write data with its slot index.
//   Modports:
//     master - drives AW/W/AR payload and valids, B/R readies.
//     slave  - the mirror image of master.
interface axi_intf #(
  parameter int ID_W   = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_id_remap.sv
// axi_id_remap: compresses 12-bit upstream AXI IDs onto small slot indices
// for the DDR path and restores the original ID on B/R responses.
//
// Ports:
//   clk         in   single clock
//   rstn        in   asynchronous active-low reset
//   s_axi_intf  axi_intf.slave   upstream side, 12-bit IDs
//   m_axi_intf  axi_intf.master  downstream side, ID = slot index, upper bits 0
//   stall_cnt   out  32-bit saturating count of cycles where an AW or AR
//                    request was stalled; only exists when the macro
//                    AXI_ID_REMAP_STAT_EN is defined.
//
// Parameters: SLOTS (entries per table, 2..64), MAX_OUT (outstanding limit
// per slot, fits the 4-bit counter), WQ_DEPTH (W-routing FIFO depth, power of 2).
module axi_id_remap #(
  parameter int SLOTS    = 8,
  parameter int MAX_OUT  = 15,
  parameter int WQ_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rstn,
  axi_intf.slave   s_axi_intf,
  axi_intf.master  m_axi_intf
`ifdef AXI_ID_REMAP_STAT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int IDW = 12;
  localparam int SW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int QW  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam logic [3:0]     MAXC     = 4'(MAX_OUT);
  localparam logic [IDW-1:0] SLOTS_ID = IDW'(SLOTS);

  typedef logic [SW-1:0] slot_t;
  typedef struct packed {
    logic  ok;
    slot_t slot;
  } look_t;

  // A hit always wins so an ID never spreads over two slots; a hit at the
  // outstanding limit stalls even if free slots exist.
  function automatic look_t lookup(
    input logic [SLOTS-1:0] vld,
    input logic [IDW-1:0]   ids [SLOTS],
    input logic [3:0]       cnt [SLOTS],
    input logic [IDW-1:0]   id
  );
    look_t      res;
    logic       hit;
    logic [3:0] hit_cnt;
    slot_t      hit_slot;
    logic       free;
    slot_t      free_slot;
    hit       = 1'b0;
    hit_cnt   = '0;
    hit_slot  = '0;
    free      = 1'b0;
    free_slot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (vld[i] && (ids[i] == id)) begin
        hit      = 1'b1;
        hit_cnt  = cnt[i];
        hit_slot = slot_t'(i);
      end
    end
    // Descending scan so the lowest free index is the one left standing.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        free      = 1'b1;
        free_slot = slot_t'(i);
      end
    end
    res.ok   = hit ? (hit_cnt < MAXC) : free;
    res.slot = hit ? hit_slot : free_slot;
    return res;
  endfunction

  function automatic logic [IDW-1:0] ext(input slot_t s);
    return {{(IDW - SW){1'b0}}, s};
  endfunction

  // Write side state
  logic [SLOTS-1:0] wt_vld;
  logic [IDW-1:0]   wt_id  [SLOTS];
  logic [3:0]       wt_cnt [SLOTS];
  logic [SLOTS-1:0] wt_inc, wt_dec;
  look_t            aw_look;
  logic             aw_ok, aw_hs;
  slot_t            b_idx;
  logic             b_in_range, b_hs;

  // Read side state
  logic [SLOTS-1:0] rt_vld;
  logic [IDW-1:0]   rt_id  [SLOTS];
  logic [3:0]       rt_cnt [SLOTS];
  logic [SLOTS-1:0] rt_inc, rt_dec;
  look_t            ar_look;
  logic             ar_ok, ar_hs;
  slot_t            r_idx;
  logic             r_in_range, r_done;

  // W-routing FIFO: slot of each accepted AW, in order
  slot_t            wq_mem [WQ_DEPTH];
  logic [QW:0]      wq_wr, wq_rd;
  logic             wq_empty, wq_full, w_pop;

  logic unused_wid;
  assign unused_wid = ^s_axi_intf.wid;

  always_comb begin
    aw_look = lookup(wt_vld, wt_id, wt_cnt, s_axi_intf.awid);
    ar_look = lookup(rt_vld, rt_id, rt_cnt, s_axi_intf.arid);
  end

  assign wq_empty = (wq_wr == wq_rd);
  assign wq_full  = (wq_wr[QW] != wq_rd[QW]) && (wq_wr[QW-1:0] == wq_rd[QW-1:0]);

  assign aw_ok = aw_look.ok && !wq_full;
  assign ar_ok = ar_look.ok;

  // Valids are gated by rstn so they drop the instant reset asserts,
  // independent of what the upstream side is still presenting.
  assign m_axi_intf.awvalid = rstn && s_axi_intf.awvalid && aw_ok;
  assign s_axi_intf.awready = m_axi_intf.awready && aw_ok;
  assign m_axi_intf.awid    = ext(aw_look.slot);
  assign m_axi_intf.awaddr  = s_axi_intf.awaddr;
  assign m_axi_intf.awlen   = s_axi_intf.awlen;
  assign m_axi_intf.awsize  = s_axi_intf.awsize;
  assign m_axi_intf.awburst = s_axi_intf.awburst;
  assign aw_hs = m_axi_intf.awvalid && m_axi_intf.awready;

  // W data is held off until its AW has been accepted and queued.
  assign m_axi_intf.wvalid = rstn && s_axi_intf.wvalid && !wq_empty;
  assign s_axi_intf.wready = m_axi_intf.wready && !wq_empty;
  assign m_axi_intf.wid    = ext(wq_mem[wq_rd[QW-1:0]]);
  assign m_axi_intf.wdata  = s_axi_intf.wdata;
  assign m_axi_intf.wstrb  = s_axi_intf.wstrb;
  assign m_axi_intf.wlast  = s_axi_intf.wlast;
  assign w_pop = m_axi_intf.wvalid && m_axi_intf.wready && s_axi_intf.wlast;

  assign b_idx      = m_axi_intf.bid[SW-1:0];
  assign b_in_range = (m_axi_intf.bid < SLOTS_ID);
  assign s_axi_intf.bvalid = rstn && m_axi_intf.bvalid;
  assign m_axi_intf.bready = s_axi_intf.bready;
  assign s_axi_intf.bresp  = m_axi_intf.bresp;
  assign s_axi_intf.bid    = b_in_range ? wt_id[b_idx] : '0;
  assign b_hs = m_axi_intf.bvalid && m_axi_intf.bready;

  assign m_axi_intf.arvalid = rstn && s_axi_intf.arvalid && ar_ok;
  assign s_axi_intf.arready = m_axi_intf.arready && ar_ok;
  assign m_axi_intf.arid    = ext(ar_look.slot);
  assign m_axi_intf.araddr  = s_axi_intf.araddr;
  assign m_axi_intf.arlen   = s_axi_intf.arlen;
  assign m_axi_intf.arsize  = s_axi_intf.arsize;
  assign m_axi_intf.arburst = s_axi_intf.arburst;
  assign ar_hs = m_axi_intf.arvalid && m_axi_intf.arready;

  assign r_idx      = m_axi_intf.rid[SW-1:0];
  assign r_in_range = (m_axi_intf.rid < SLOTS_ID);
  assign s_axi_intf.rvalid = rstn && m_axi_intf.rvalid;
  assign m_axi_intf.rready = s_axi_intf.rready;
  assign s_axi_intf.rdata  = m_axi_intf.rdata;
  assign s_axi_intf.rresp  = m_axi_intf.rresp;
  assign s_axi_intf.rlast  = m_axi_intf.rlast;
  assign s_axi_intf.rid    = r_in_range ? rt_id[r_idx] : '0;
  assign r_done = m_axi_intf.rvalid && m_axi_intf.rready && m_axi_intf.rlast;

  // Per-slot take/release strobes. A release against an idle slot is a
  // protocol violation and is ignored so the counter cannot underflow.
  always_comb begin
    wt_inc = '0;
    wt_dec = '0;
    rt_inc = '0;
    rt_dec = '0;
    for (int i = 0; i < SLOTS; i++) begin
      wt_inc[i] = aw_hs && (aw_look.slot == slot_t'(i));
      wt_dec[i] = b_hs && b_in_range && (b_idx == slot_t'(i)) && wt_vld[i] && (wt_cnt[i] != 4'd0);
      rt_inc[i] = ar_hs && (ar_look.slot == slot_t'(i));
      rt_dec[i] = r_done && r_in_range && (r_idx == slot_t'(i)) && rt_vld[i] && (rt_cnt[i] != 4'd0);
    end
  end

  // Write table: a take and a release on the same slot cancel out and the
  // entry stays valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wt_vld <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        wt_id[i]  <= '0;
        wt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (wt_inc[i] && !wt_dec[i]) begin
          wt_cnt[i] <= wt_cnt[i] + 4'd1;
        end else if (!wt_inc[i] && wt_dec[i]) begin
          wt_cnt[i] <= wt_cnt[i] - 4'd1;
        end
        if (wt_inc[i]) begin
          wt_vld[i] <= 1'b1;
          wt_id[i]  <= s_axi_intf.awid;
        end else if (wt_dec[i] && (wt_cnt[i] == 4'd1)) begin
          wt_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Read table: only the last beat of a burst releases the slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rt_vld <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        rt_id[i]  <= '0;
        rt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (rt_inc[i] && !rt_dec[i]) begin
          rt_cnt[i] <= rt_cnt[i] + 4'd1;
        end else if (!rt_inc[i] && rt_dec[i]) begin
          rt_cnt[i] <= rt_cnt[i] - 4'd1;
        end
        if (rt_inc[i]) begin
          rt_vld[i] <= 1'b1;
          rt_id[i]  <= s_axi_intf.arid;
        end else if (rt_dec[i] && (rt_cnt[i] == 4'd1)) begin
          rt_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wq_wr <= '0;
      wq_rd <= '0;
    end else begin
      if (aw_hs) wq_wr <= wq_wr + (QW+1)'(1);
      if (w_pop) wq_rd <= wq_rd + (QW+1)'(1);
    end
  end

  // FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (aw_hs) wq_mem[wq_wr[QW-1:0]] <= aw_look.slot;
  end

`ifdef AXI_ID_REMAP_STAT_EN
  // One increment per cycle in which either request channel is held off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (((s_axi_intf.awvalid && !aw_ok) || (s_axi_intf.arvalid && !ar_ok)) &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_id_remap.sv
// tb_axi_id_remap: scoreboard bench for axi_id_remap. The bench plays both
// the upstream master and the downstream slave. Expected downstream IDs and
// restored upstream IDs are queued when stimulus is driven and compared
// when the matching handshake is seen.
module tb_axi_id_remap;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_intf #(.ID_W(12)) s_if ();
  axi_intf #(.ID_W(12)) m_if ();

`ifdef AXI_ID_REMAP_STAT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_base;
`endif

  axi_id_remap #(.SLOTS(8), .MAX_OUT(15), .WQ_DEPTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_axi_intf (s_if),
    .m_axi_intf (m_if)
`ifdef AXI_ID_REMAP_STAT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [11:0] exp_aw_q [$];
  logic [11:0] exp_w_q  [$];
  logic [11:0] exp_b_q  [$];
  logic [11:0] exp_ar_q [$];
  logic [11:0] exp_r_q  [$];

  int w_out [64];
  int r_out [64];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic aw_req(input logic [11:0] id, input logic [11:0] exp_slot);
    bit done;
    done = 1'b0;
    exp_aw_q.push_back(exp_slot);
    s_if.awvalid = 1'b1;
    s_if.awid    = id;
    s_if.awaddr  = $urandom;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (s_if.awready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.awvalid = 1'b0;
    checkOutput("aw_accept", 32'(done), 32'd1);
  endtask

  task automatic ar_req(input logic [11:0] id, input logic [11:0] exp_slot);
    bit done;
    done = 1'b0;
    exp_ar_q.push_back(exp_slot);
    s_if.arvalid = 1'b1;
    s_if.arid    = id;
    s_if.araddr  = $urandom;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (s_if.arready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.arvalid = 1'b0;
    checkOutput("ar_accept", 32'(done), 32'd1);
  endtask

  task automatic w_burst(input logic [11:0] exp_slot, input int beats);
    bit done;
    exp_w_q.push_back(exp_slot);
    for (int b = 0; b < beats; b++) begin
      done = 1'b0;
      s_if.wvalid = 1'b1;
      s_if.wlast  = (b == beats - 1);
      s_if.wdata  = $urandom;
      for (int c = 0; c < 50 && !done; c++) begin
        #1;
        if (s_if.wready) done = 1'b1;
        @(posedge clk);
        #1;
      end
      checkOutput("w_accept", 32'(done), 32'd1);
    end
    s_if.wvalid = 1'b0;
    s_if.wlast  = 1'b0;
  endtask

  task automatic b_resp(input logic [11:0] slot, input logic [11:0] exp_id);
    exp_b_q.push_back(exp_id);
    m_if.bvalid = 1'b1;
    m_if.bid    = slot;
    tick();
    m_if.bvalid = 1'b0;
  endtask

  task automatic r_burst(input logic [11:0] slot, input int beats, input logic [11:0] exp_id);
    exp_r_q.push_back(exp_id);
    for (int b = 0; b < beats; b++) begin
      m_if.rvalid = 1'b1;
      m_if.rid    = slot;
      m_if.rlast  = (b == beats - 1);
      m_if.rdata  = $urandom;
      tick();
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
  endtask

  // Handshakes are stable from just after one rising edge to the next, so a
  // falling-edge sample sees exactly what the coming edge will transfer.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_if.awvalid && m_if.awready) begin
        if (exp_aw_q.size() == 0) checkOutput("aw_unexpected", m_if.awid, 32'hFFFF_FFFF);
        else checkOutput("m_awid", m_if.awid, exp_aw_q.pop_front());
        w_out[m_if.awid[5:0]]++;
      end
      if (m_if.wvalid && m_if.wready) begin
        if (exp_w_q.size() == 0) checkOutput("w_unexpected", m_if.wid, 32'hFFFF_FFFF);
        else begin
          checkOutput("m_wid", m_if.wid, exp_w_q[0]);
          if (m_if.wlast) void'(exp_w_q.pop_front());
        end
      end
      if (m_if.bvalid && m_if.bready) begin
        assert (w_out[m_if.bid[5:0]] > 0)
          else $error("[TB] B response on idle slot %0d", m_if.bid);
        if (w_out[m_if.bid[5:0]] > 0) w_out[m_if.bid[5:0]]--;
      end
      if (s_if.bvalid && s_if.bready) begin
        if (exp_b_q.size() == 0) checkOutput("b_unexpected", s_if.bid, 32'hFFFF_FFFF);
        else checkOutput("s_bid", s_if.bid, exp_b_q.pop_front());
      end
      if (m_if.arvalid && m_if.arready) begin
        if (exp_ar_q.size() == 0) checkOutput("ar_unexpected", m_if.arid, 32'hFFFF_FFFF);
        else checkOutput("m_arid", m_if.arid, exp_ar_q.pop_front());
        r_out[m_if.arid[5:0]]++;
      end
      if (m_if.rvalid && m_if.rready && m_if.rlast) begin
        assert (r_out[m_if.rid[5:0]] > 0)
          else $error("[TB] R response on idle slot %0d", m_if.rid);
        if (r_out[m_if.rid[5:0]] > 0) r_out[m_if.rid[5:0]]--;
      end
      if (s_if.rvalid && s_if.rready) begin
        if (exp_r_q.size() == 0) checkOutput("r_unexpected", s_if.rid, 32'hFFFF_FFFF);
        else begin
          checkOutput("s_rid", s_if.rid, exp_r_q[0]);
          if (s_if.rlast) void'(exp_r_q.pop_front());
        end
      end
    end
  end

  task automatic print_summary;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
  endtask

  task automatic applyStimulus;
    // Reset: every valid is forced low even with the inputs asserted.
    s_if.awvalid = 1'b1; s_if.arvalid = 1'b1; s_if.wvalid = 1'b1;
    m_if.bvalid  = 1'b1; m_if.rvalid  = 1'b1;
    #12;
    checkOutput("rst_m_awvalid", m_if.awvalid, 0);
    checkOutput("rst_m_arvalid", m_if.arvalid, 0);
    checkOutput("rst_m_wvalid",  m_if.wvalid,  0);
    checkOutput("rst_s_bvalid",  s_if.bvalid,  0);
    checkOutput("rst_s_rvalid",  s_if.rvalid,  0);
    s_if.awvalid = 1'b0; s_if.arvalid = 1'b0; s_if.wvalid = 1'b0;
    m_if.bvalid  = 1'b0; m_if.rvalid  = 1'b0;
    #10 rstn = 1'b1;
    tick();

    // Single 4-beat write, then the freed slot 0 goes to a new ID.
    aw_req(12'h3A5, 0);
    w_burst(0, 4);
    b_resp(0, 12'h3A5);
    aw_req(12'h111, 0);
    w_burst(0, 1);
    b_resp(0, 12'h111);

    // W presented three cycles before its AW.
    s_if.wvalid = 1'b1;
    s_if.wlast  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("w_before_aw", s_if.wready, 0);
      tick();
    end
    aw_req(12'h222, 0);
    #1;
    checkOutput("w_after_aw", s_if.wready, 1);
    w_burst(0, 2);
    b_resp(0, 12'h222);

    // Eight AWs pending W fill the routing FIFO; a ninth must wait.
    for (int i = 0; i < 8; i++) aw_req(12'h300 + 12'(i), 12'(i));
    s_if.awvalid = 1'b1;
    s_if.awid    = 12'h300;
    #1;
    checkOutput("aw_fifo_full", s_if.awready, 0);
    checkOutput("m_awvalid_fifo_full", m_if.awvalid, 0);
    tick();
    s_if.awvalid = 1'b0;
    w_burst(0, 1);
    aw_req(12'h300, 0);
    for (int i = 1; i < 8; i++) w_burst(12'(i), 1);
    w_burst(0, 1);
    b_resp(0, 12'h300);
    b_resp(0, 12'h300);
    for (int i = 1; i < 8; i++) b_resp(12'(i), 12'h300 + 12'(i));

    // Same-cycle take and release on slot 2 holding one transaction.
    aw_req(12'h400, 0);
    aw_req(12'h401, 1);
    aw_req(12'h402, 2);
    w_burst(0, 1);
    w_burst(1, 1);
    w_burst(2, 1);
    exp_aw_q.push_back(2);
    exp_b_q.push_back(12'h402);
    s_if.awvalid = 1'b1;
    s_if.awid    = 12'h402;
    m_if.bvalid  = 1'b1;
    m_if.bid     = 2;
    #1;
    checkOutput("aw_same_cycle", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    m_if.bvalid  = 1'b0;
    w_burst(2, 1);
    b_resp(2, 12'h402);
    aw_req(12'h4FF, 2);
    w_burst(2, 1);
    b_resp(0, 12'h400);
    b_resp(1, 12'h401);
    b_resp(2, 12'h4FF);

    // Nine distinct read IDs against eight slots.
    for (int i = 0; i < 8; i++) ar_req(12'h100 + 12'(i), 12'(i));
    s_if.arvalid = 1'b1;
    s_if.arid    = 12'h108;
`ifdef AXI_ID_REMAP_STAT_EN
    stall_base = stall_cnt;
`endif
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("ar_no_slot", s_if.arready, 0);
      tick();
    end
    exp_r_q.push_back(12'h103);
    m_if.rvalid = 1'b1;
    m_if.rid    = 3;
    m_if.rlast  = 1'b1;
    #1;
    checkOutput("ar_free_next_cycle", s_if.arready, 0);
    tick();
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    #1;
    checkOutput("ar_took_freed", s_if.arready, 1);
`ifdef AXI_ID_REMAP_STAT_EN
    checkOutput("stall_cnt_delta", stall_cnt - stall_base, 5);
`endif
    exp_ar_q.push_back(3);
    tick();
    s_if.arvalid = 1'b0;
    for (int i = 0; i < 8; i++)
      r_burst(12'(i), (i == 5) ? 3 : 1, (i == 3) ? 12'h108 : 12'h100 + 12'(i));

    // Sixteen reads on one ID: the sixteenth waits for an rlast.
    for (int k = 0; k < 15; k++) ar_req(12'h7FF, 0);
    s_if.arvalid = 1'b1;
    s_if.arid    = 12'h7FF;
    #1;
    checkOutput("ar_max_out", s_if.arready, 0);
    tick();
    exp_r_q.push_back(12'h7FF);
    for (int b = 0; b < 3; b++) begin
      m_if.rvalid = 1'b1;
      m_if.rid    = 0;
      m_if.rlast  = (b == 2);
      #1;
      checkOutput("ar_wait_rlast", s_if.arready, 0);
      tick();
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    #1;
    checkOutput("ar_after_rlast", s_if.arready, 1);
    exp_ar_q.push_back(0);
    tick();
    s_if.arvalid = 1'b0;
    for (int k = 0; k < 15; k++) r_burst(0, 1, 12'h7FF);

    // Reset in the middle of a write burst with reads outstanding.
    ar_req(12'h500, 0);
    ar_req(12'h501, 1);
    ar_req(12'h502, 2);
    aw_req(12'h600, 0);
    exp_w_q.push_back(0);
    s_if.wvalid = 1'b1;
    s_if.wlast  = 1'b0;
    tick();
    s_if.arvalid = 1'b1;
    s_if.arid    = 12'h503;
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_m_wvalid",  m_if.wvalid,  0);
    checkOutput("midrst_m_arvalid", m_if.arvalid, 0);
    s_if.arvalid = 1'b0;
    exp_w_q.delete();
    foreach (w_out[i]) w_out[i] = 0;
    foreach (r_out[i]) r_out[i] = 0;
    #10 rstn = 1'b1;
    tick();
    s_if.wlast = 1'b1;
    #1;
    checkOutput("w_fifo_cleared", m_if.wvalid, 0);
    s_if.wvalid = 1'b0;
    s_if.wlast  = 1'b0;
    tick();
    ar_req(12'h777, 0);
    aw_req(12'h888, 0);
    w_burst(0, 1);
    b_resp(0, 12'h888);
    r_burst(0, 1, 12'h777);

    tick();
    tick();
    checkOutput("aw_q_drained", exp_aw_q.size(), 0);
    checkOutput("w_q_drained",  exp_w_q.size(),  0);
    checkOutput("b_q_drained",  exp_b_q.size(),  0);
    checkOutput("ar_q_drained", exp_ar_q.size(), 0);
    checkOutput("r_q_drained",  exp_r_q.size(),  0);
  endtask

  initial begin
    s_if.awvalid = 0; s_if.awid = 0; s_if.awaddr = 0; s_if.awlen = 0;
    s_if.awsize = 3'd2; s_if.awburst = 2'd1;
    s_if.wvalid = 0; s_if.wid = 0; s_if.wdata = 0; s_if.wstrb = '1; s_if.wlast = 0;
    s_if.bready = 1;
    s_if.arvalid = 0; s_if.arid = 0; s_if.araddr = 0; s_if.arlen = 0;
    s_if.arsize = 3'd2; s_if.arburst = 2'd1;
    s_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    m_if.bvalid = 0; m_if.bid = 0; m_if.bresp = 0;
    m_if.rvalid = 0; m_if.rid = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rlast = 0;
    foreach (w_out[i]) w_out[i] = 0;
    foreach (r_out[i]) r_out[i] = 0;
    $display("[TB] axi_id_remap bench start");
    applyStimulus();
    print_summary();
    $finish;
  end

  initial begin
    #300000;
    n_miscompares++;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    print_summary();
    $finish;
  end

endmodule
